// File: rtl/dac_arb_pkg.sv
// Shared types and helpers for the DAC channel arbiter.
package dac_arb_pkg;

  // Width of the DAC channel address carried on m_axis_tuser
  localparam int ADDR_W = 3;

  typedef enum logic {
    ARB  = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              found;
    logic [ADDR_W-1:0] idx;
  } rr_sel_t;

  // Left-justify a sample by padding `pad` zero LSBs; caller truncates to DAC width
  function automatic logic [31:0] widen(input logic [31:0] sample, input int pad);
    return sample << pad;
  endfunction

  // Round-robin pick: first set bit of mask searching ptr+1, ptr+2, ... modulo n
  function automatic rr_sel_t rr_next(input logic [7:0] mask,
                                      input logic [ADDR_W-1:0] ptr,
                                      input int n);
    rr_sel_t r;
    int      j;
    r = '0;
    for (int k = 1; k <= 8; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !r.found && mask[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dac_channel_arbiter_stale_monitor.sv
// Single-channel silence detector: saturating counter plus sticky flag.
module stale_monitor #(
  parameter int TIMEOUT = 5000000,
  parameter int CNT_W   = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic accept,
  output logic stale
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stale_q, stale_d;

  // Next count: held at 0 when disabled, cleared by an accept, else saturating increment
  always_comb begin
    cnt_d   = cnt_q;
    stale_d = stale_q;
    if (!en || accept) begin
      cnt_d   = '0;
      stale_d = 1'b0;
    end else begin
      if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
      stale_d = (cnt_d == CNT_W'(TIMEOUT));
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  assign stale = stale_q;

endmodule

// File: rtl/dac_channel_arbiter.sv
// Round-robin mux of NUM_CH ADC sample streams onto one SPI DAC stream.
module dac_channel_arbiter
  import dac_arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12,
  parameter int DAC_W   = 14,
  parameter int CH_BASE = 0,
  parameter int TIMEOUT = 5000000,
  parameter int CNT_W   = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DAC_W-1:0]         m_axis_tdata,
  output logic [ADDR_W-1:0]        m_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [ADDR_W-1:0]        grant_idx,
  output logic [NUM_CH-1:0]        stale
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] grant_q, grant_d;
  logic [DAC_W-1:0]  tdata_q, tdata_d;
  logic [ADDR_W-1:0] tuser_q, tuser_d;
  logic              tvalid_q, tvalid_d;

  logic [NUM_CH-1:0] cand;
  rr_sel_t           sel;
  logic [DATA_W-1:0] smp [NUM_CH];
  logic [DATA_W-1:0] sel_smp;

  assign cand = ch_en & s_axis_tvalid;
  assign sel  = rr_next(8'(cand), ptr_q, NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign smp[g] = s_axis_tdata[g*DATA_W +: DATA_W];
  end

  // Mux the winning sample out by compare rather than variable index
  always_comb begin
    sel_smp = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel.idx == ADDR_W'(i)) sel_smp = smp[i];
  end

  // Ready: disabled channels drain freely; in ARB only the winner is accepted
  always_comb begin
    s_axis_tready = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_en[i])
          s_axis_tready[i] = 1'b1;
        else if (state_q == ARB && sel.found && sel.idx == ADDR_W'(i))
          s_axis_tready[i] = 1'b1;
      end
    end
  end

  // Arbiter FSM next state and output word capture
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    case (state_q)
      ARB: begin
        if (sel.found) begin
          tdata_d  = DAC_W'(widen(32'(sel_smp), DAC_W - DATA_W));
          tuser_d  = ADDR_W'(CH_BASE) + sel.idx;
          tvalid_d = 1'b1;
          ptr_d    = sel.idx;
          grant_d  = sel.idx;
          state_d  = SEND;
        end
      end
      SEND: begin
        // Word completes even if its channel is disabled meanwhile
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State and output registers; reset drops any in-flight word at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      ptr_q    <= ADDR_W'(NUM_CH - 1);
      grant_q  <= '0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign grant_idx     = grant_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stale
    stale_monitor #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_mon (
      .clk    (clk),
      .rst    (rst),
      .en     (ch_en[g]),
      .accept (s_axis_tvalid[g] & s_axis_tready[g]),
      .stale  (stale[g])
    );
  end

endmodule

// File: tb/tb_dac_channel_arbiter.sv
// Randomized bench for dac_channel_arbiter against a transaction-level model.
module tb_dac_channel_arbiter;

  localparam int N  = 4;
  localparam int DW = 12;
  localparam int OW = 14;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  ch_en = '0;
  logic [N*DW-1:0] s_axis_tdata = '0;
  logic [N-1:0]  s_axis_tvalid = '0;
  logic [N-1:0]  s_axis_tready;
  logic [OW-1:0] m_axis_tdata;
  logic [2:0]    m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [2:0]    grant_idx;
  logic [N-1:0]  stale;

  dac_channel_arbiter #(
    .NUM_CH(N), .DATA_W(DW), .DAC_W(OW), .CH_BASE(0), .TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .grant_idx(grant_idx), .stale(stale)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: busy flag, last-winner pointer, pending word, silence age per channel
  bit          m_busy;
  int          m_ptr, m_grant, m_user, m_data;
  bit          m_valid;
  int          m_age [N];
  int          sample [N];
  logic [N-1:0] exp_rdy;
  int          hs_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = N - 1; m_grant = 0; m_user = 0; m_data = 0; m_valid = 0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  function automatic int pick();
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (m_ptr + k) % N;
      if (ch_en[j] && s_axis_tvalid[j]) return j;
    end
    return -1;
  endfunction

  // One clock: drive inputs at the falling edge, check, then advance the model
  task automatic step(input logic r, input logic [N-1:0] en, input logic [N-1:0] vld, input logic mrdy);
    int w;
    @(negedge clk);
    rst = r; ch_en = en; s_axis_tvalid = vld; m_axis_tready = mrdy;
    for (int i = 0; i < N; i++) s_axis_tdata[i*DW +: DW] = DW'(sample[i]);
    #1;
    if (r) model_reset();
    w = pick();
    exp_rdy = '0;
    if (!r)
      for (int i = 0; i < N; i++)
        exp_rdy[i] = !en[i] || (!m_busy && w == i);
    chk("tready", 32'(s_axis_tready), 32'(exp_rdy));
    chk("tvalid", 32'(m_axis_tvalid), 32'(m_valid));
    chk("tdata",  32'(m_axis_tdata), 32'(m_data));
    chk("tuser",  32'(m_axis_tuser), 32'(m_user));
    chk("grant",  32'(grant_idx), 32'(m_grant));
    for (int i = 0; i < N; i++)
      chk("stale", 32'(stale[i]), 32'(en[i] && m_age[i] >= TO));
    if (!r) begin
      for (int i = 0; i < N; i++) begin
        if (!en[i] || (vld[i] && exp_rdy[i])) m_age[i] = 0;
        else if (m_age[i] < TO) m_age[i]++;
      end
      if (!m_busy) begin
        if (w >= 0) begin
          m_data = (sample[w] * 4) & 16'h3FFF;
          m_user = w; m_grant = w; m_ptr = w; m_valid = 1; m_busy = 1;
        end
      end else if (mrdy) begin
        m_valid = 0; m_busy = 0; hs_count++;
      end
    end
  endtask

  initial begin
    model_reset();
    hs_count = 0;
    for (int i = 0; i < N; i++) sample[i] = (i + 1) * 256;

    // Reset held with all sources valid
    repeat (3) step(1'b1, 4'hF, 4'hF, 1'b1);

    // Round-robin with all channels valid; first grant must be channel 0
    step(1'b0, 4'hF, 4'hF, 1'b1);
    step(1'b0, 4'hF, 4'hF, 1'b1);
    chk("first_grant_ch", 32'(m_axis_tuser), 32'd0);
    chk("first_grant_data", 32'(m_axis_tdata), 32'h0400);
    repeat (14) step(1'b0, 4'hF, 4'hF, 1'b1);

    // Backpressure for 20 cycles then release: exactly one handshake
    repeat (20) step(1'b0, 4'hF, 4'hF, 1'b0);
    hs_count = 0;
    step(1'b0, 4'hF, 4'hF, 1'b1);
    chk("bp_one_hs", 32'(hs_count), 32'd1);

    // Channel 2 disabled but valid: drained, never granted
    for (int c = 0; c < 30; c++) begin
      step(1'b0, 4'b1011, 4'hF, 1'b1);
      if (m_axis_tvalid) chk("dis_no_ch2", 32'(m_axis_tuser == 3'd2), 32'd0);
    end

    // Channel 1 silent long enough to go stale, then one accept clears it
    repeat (120) step(1'b0, 4'hF, 4'b1101, 1'b1);
    chk("stale1_set", 32'(stale[1]), 32'd1);
    repeat (10) step(1'b0, 4'hF, 4'hF, 1'b1);
    chk("stale1_clr", 32'(stale[1]), 32'd0);

    // Reset during SEND: output valid must drop without a clock edge
    step(1'b0, 4'hF, 4'hF, 1'b0);
    step(1'b0, 4'hF, 4'hF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("async_drop", 32'(m_axis_tvalid), 32'd0);
    step(1'b1, 4'hF, 4'hF, 1'b1);
    step(1'b0, 4'hF, 4'hF, 1'b1);
    step(1'b0, 4'hF, 4'hF, 1'b1);
    chk("restart_ch0", 32'(m_axis_tuser), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) sample[i] = $urandom_range(0, 4095);
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'hF,
           N'($urandom),
           1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
